des_key_sched_ctrl: RTL

Sequencer for the DES key schedule. It takes the 28-bit C0/D0 halves produced by `PC_1` and steps through the 16 rounds, rotating C/D by the standard shift schedule. Each round it emits one 48-bit round key through the PC-2 permutation over a valid/ready handshake. Keys come out in K1..K16 order for encryption or K16..K1 for decryption, and the block feeds the round datapath.

---
 rtl/des_pkg.sv | 48 ++++
 rtl/des_key_sched_ctrl_pc_2.sv | 13 +
 rtl/des_key_sched_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// Shared constants, types and rotation helpers for the DES key schedule sequencer.
// Holds the per-round shift amounts and the PC-2 selection table.
package des_pkg;

    localparam int unsigned HALF_W   = 32'd28;
    localparam int unsigned KEY_W    = 32'd48;
    localparam int unsigned IDX_W    = 32'd4;
    localparam int unsigned ROUNDS_N = 32'd16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Left-rotation amount applied to reach round r+1 (index 0 is round 1).
    localparam logic [1:0] SHIFT_SCHED [0:15] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // PC-2 source positions, 1-based from the MSB of the 56-bit {C, D} word.
    localparam logic [5:0] PC2_IDX [0:47] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
        6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
        6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
        6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
        6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[26:0], x[27]};
            2'd2:    return {x[25:0], x[27:26]};
            default: return x;
        endcase
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_key_sched_ctrl_pc_2.sv
// PC-2 compression permutation: selects 48 of the 56 bits of {C, D}.
module PC_2
    import des_pkg::*;
(
    input  logic [55:0] cd_i,
    output logic [47:0] key_o
);

    for (genvar i = 0; i < 48; i++) begin : g_sel
        assign key_o[47 - i] = cd_i[32'd56 - 32'(PC2_IDX[i])];
    end

endmodule

// File: rtl/des_key_sched_ctrl.sv
// DES key schedule sequencer: rotates C/D per round and streams the 16 round
// keys over valid/ready, forward for encryption or reversed for decryption.
module des_key_sched_ctrl
    import des_pkg::*;
#(
    parameter int unsigned ROUNDS = 32'd16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Decrypt,
    input  logic [27:0] C0,
    input  logic [27:0] D0,
    input  logic        Key_ready,
    output logic [47:0] Round_key,
    output logic        Key_valid,
    output logic [3:0]  Round_idx,
    output logic        Busy,
    output logic        Done
);

    localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 32'd1);

    state_e      state_q;
    logic [27:0] c_q;
    logic [27:0] d_q;
    logic [3:0]  idx_q;
    logic        dec_q;
    logic        valid_q;
    logic        busy_q;
    logic        done_q;

    logic [1:0]  shamt_s;
    logic        last_s;
    logic [27:0] c_d;
    logic [27:0] d_d;
    logic [27:0] c_load_s;
    logic [27:0] d_load_s;

    // Next C/D for a handshake: decrypt undoes the current round's shift, encrypt applies the next one.
    always_comb begin
        shamt_s  = dec_q ? SHIFT_SCHED[idx_q] : SHIFT_SCHED[idx_q + 4'd1];
        c_d      = dec_q ? rotr28(c_q, shamt_s) : rotl28(c_q, shamt_s);
        d_d      = dec_q ? rotr28(d_q, shamt_s) : rotl28(d_q, shamt_s);
        last_s   = dec_q ? (idx_q == 4'd0) : (idx_q == LAST_IDX);
        c_load_s = Decrypt ? C0 : rotl28(C0, 2'd1);
        d_load_s = Decrypt ? D0 : rotl28(D0, 2'd1);
    end

    // Sequencer FSM with all status outputs registered.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            c_q     <= 28'd0;
            d_q     <= 28'd0;
            idx_q   <= 4'd0;
            dec_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        state_q <= ST_RUN;
                        c_q     <= c_load_s;
                        d_q     <= d_load_s;
                        idx_q   <= Decrypt ? LAST_IDX : 4'd0;
                        dec_q   <= Decrypt;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (Key_ready) begin
                        if (last_s) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            c_q   <= c_d;
                            d_q   <= d_d;
                            idx_q <= dec_q ? (idx_q - 4'd1) : (idx_q + 4'd1);
                        end
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    PC_2 u_pc_2 (
        .cd_i  ({c_q, d_q}),
        .key_o (Round_key)
    );

    assign Key_valid = valid_q;
    assign Round_idx = idx_q;
    assign Busy      = busy_q;
    assign Done      = done_q;

endmodule
